wta_frame_ctrl: RTL and testbench
=================================

Name: wta_frame_ctrl

Overview:
Frame sequencer for the 8-channel winner-take-all PWM array. It commits the SPI-loaded pulse-width, enable and k-threshold configuration when SPI1 select falls. It then runs one measurement frame, driving per-channel PWM and timing each channel's response pulse. At frame end it holds the 12-bit per-channel counts, the NN one-hot winner and the KNN mask for SPI readback.

Parameters:
NCH, 8, number of channels
CW, 12, pulse-width / count width
FRAME_MAX, 4095, last frame-counter value (timeout); must fit in CW bits

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_ss_1  in  1  SPI1 select, active high; 1->0 transition = config commit
i_pw  in  NCH*CW  pulse widths; channel c = bits [c*CW +: CW]
i_switch  in  NCH  channel enable mask
i_knn_k  in  3  KNN winner count K (0..7)
i_pulse  in  NCH  channel response levels, synchronous to clk
o_pwm  out  NCH  registered PWM drive
o_cnt  out  NCH*CW  per-channel arrival time, same packing as i_pw
o_nn  out  NCH  one-hot first arrival (NN result)
o_knn  out  NCH  mask of first K arrivals (KNN result)
o_busy  out  1  high in ARM and RUN
o_done  out  1  high in DONE until next ARM

Behaviour:
- Reset: state IDLE, ss_q=0, fc=0, shadow regs 0, all outputs 0.
- commit = ss_q & ~i_ss_1. ss_q <= i_ss_1 every cycle.
- States: IDLE, ARM, RUN, DONE.
- IDLE/DONE -commit-> ARM.
- RUN -commit-> ARM: abort and restart. Partial results are discarded.
- ARM (1 cycle):
  - Latch shadow pw/en/K from inputs.
  - fc=0; arrived=0; kcnt=0; o_nn=0; o_knn=0; o_pwm=0.
  - o_cnt[c] = en[c] ? FRAME_MAX : 0.
  - Next state: RUN if en!=0, else DONE.
- RUN, cycle with frame count fc=n:
  - o_pwm[c] is high exactly during the RUN cycles with n < pw[c] and en[c]=1. pw=0 -> never high. pw>FRAME_MAX is impossible (CW bits).
  - arrive[c] = en[c] & i_pulse[c] & ~arrived[c] (level-sensitive). On arrive: o_cnt[c]<=n, arrived[c]<=1.
  - NN: if o_nn==0 and any arrive, o_nn <= one-hot of lowest-index arriving channel. Set once per frame.
  - KNN: arriving channels are admitted in ascending index while kcnt<K; kcnt increments per admission. Simultaneous arrivals beyond K are not admitted. K=0 -> o_knn stays 0. K >= number of enabled channels -> all arrivals admitted.
  - fc increments by 1 each RUN cycle; it never wraps.
  - RUN->DONE after the cycle where fc==FRAME_MAX, or where all enabled channels have arrived (including arrivals in that cycle). Arrivals at fc==FRAME_MAX record FRAME_MAX.
- DONE: o_pwm=0, o_busy=0, o_done=1. o_cnt/o_nn/o_knn are held stable for SPI readback.
- Config inputs are ignored except on the ARM cycle. SPI shifting during RUN does not disturb the frame.
- Async reset mid-frame returns to IDLE immediately and clears all outputs.

Optional Feature:
WTA_INHIBIT_EN.
- Defined: from the cycle after o_nn becomes nonzero, o_pwm is forced 0 on every channel except the winner (lateral inhibition). Arrival timing, KNN and frame end are unaffected.
- Undefined: channels' PWM run independently for their full widths.

Decomposition:
- Shared package wta_pkg holds:
  - NCH, CW, FRAME_MAX constants
  - state enum (IDLE, ARM, RUN, DONE)
  - helper that slices channel c from a packed NCH*CW bus
- One natural sub-module, wta_rank: combinational priority logic.
  - Inputs: arrive vector, current o_nn/o_knn, kcnt, K.
  - Outputs: nn_next, knn_next, kcnt_next.
  - Instanced once in the top.

Test Plan:
- Reset with i_ss_1=1 -> all outputs 0, state IDLE. Release and drop i_ss_1 -> o_busy=1 on the following cycle.
- pw[0]=5, pw[3]=0, en=8'h09, no pulses -> o_pwm[0] high exactly 5 cycles, o_pwm[3] never high. DONE after 4096 RUN cycles; o_cnt ch0=ch3=4095, others 0; o_nn=o_knn=0.
- en=FF, K=3; i_pulse[5] at fc=10, pulses[1],[2],[6] together at fc=20, the remaining channels at fc=30 -> o_nn=8'h20, o_knn=8'h26; o_cnt ch5=10, ch1=20, ch6=20; DONE right after fc=30.
- en=0 commit -> ARM then DONE directly; every result 0, no o_pwm activity.
- Commit during RUN at fc=100 with new pw -> ARM, results cleared; new frame uses the new config and old arrivals are absent.
- WTA_INHIBIT_EN defined, all pw=50, ch2 arrives at fc=3 -> from fc=4 only o_pwm[2] high, through fc=49.

Source files
------------

// File: rtl/wta_pkg.sv
// rtl/wta_pkg.sv - shared constants, state encoding and bus helper for the WTA frame sequencer
package wta_pkg;

  localparam int NCH = 8;
  localparam int CW  = 12;
  localparam int KW  = 3;
  localparam logic [CW-1:0] FRAME_MAX = 12'd4095;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [CW-1:0] ch_slice(input logic [NCH*CW-1:0] bus, input int c);
    return bus[c*CW +: CW];
  endfunction

endpackage

// File: rtl/wta_rank.sv
// rtl/wta_rank.sv - NN/KNN admission priority for one frame cycle
module wta_rank
  import wta_pkg::*;
(
  input  logic [NCH-1:0] arrive,
  input  logic [NCH-1:0] nn,
  input  logic [NCH-1:0] knn,
  input  logic [KW-1:0]  kcnt,
  input  logic [KW-1:0]  k,
  output logic [NCH-1:0] nn_next,
  output logic [NCH-1:0] knn_next,
  output logic [KW-1:0]  kcnt_next
);

  always_comb begin
    nn_next   = nn;
    knn_next  = knn;
    kcnt_next = kcnt;
    // Descending scan so the lowest arriving index is the last writer.
    for (int c = NCH - 1; c >= 0; c--) begin
      if (nn == '0 && arrive[c]) begin
        nn_next    = '0;
        nn_next[c] = 1'b1;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (arrive[c] && (kcnt_next < k)) begin
        knn_next[c] = 1'b1;
        kcnt_next   = kcnt_next + KW'(1);
      end
    end
  end

endmodule

// File: rtl/wta_frame_ctrl.sv
// rtl/wta_frame_ctrl.sv - WTA frame sequencer: config commit, PWM drive, arrival timing, NN/KNN results
// Optional lateral inhibition of non-winner PWM is enabled by defining WTA_INHIBIT_EN.
module wta_frame_ctrl
  import wta_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ss_1,
  input  logic [NCH*CW-1:0] i_pw,
  input  logic [NCH-1:0]    i_switch,
  input  logic [KW-1:0]     i_knn_k,
  input  logic [NCH-1:0]    i_pulse,
  output logic [NCH-1:0]    o_pwm,
  output logic [NCH*CW-1:0] o_cnt,
  output logic [NCH-1:0]    o_nn,
  output logic [NCH-1:0]    o_knn,
  output logic              o_busy,
  output logic              o_done
);

  state_e            state_q, state_d;
  logic              ss_q, ss_d;
  logic [CW-1:0]     fc_q, fc_d;
  logic [NCH*CW-1:0] pw_q, pw_d;
  logic [NCH-1:0]    en_q, en_d;
  logic [KW-1:0]     k_q, k_d;
  logic [NCH-1:0]    arrived_q, arrived_d;
  logic [KW-1:0]     kcnt_q, kcnt_d;
  logic [NCH-1:0]    pwm_q, pwm_d;
  logic [NCH*CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]    nn_q, nn_d;
  logic [NCH-1:0]    knn_q, knn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              commit;
  logic [NCH-1:0]    arrive;
  logic [NCH-1:0]    nn_rank, knn_rank;
  logic [KW-1:0]     kcnt_rank;
  logic [CW-1:0]     fc_inc;
  logic              frame_end;

  assign commit    = ss_q & ~i_ss_1;
  assign arrive    = (state_q == ST_RUN) ? (en_q & i_pulse & ~arrived_q) : '0;
  assign fc_inc    = fc_q + CW'(1);
  assign frame_end = (fc_q == FRAME_MAX) || (((arrived_q | arrive) & en_q) == en_q);

  wta_rank u_rank (
    .arrive    (arrive),
    .nn        (nn_q),
    .knn       (knn_q),
    .kcnt      (kcnt_q),
    .k         (k_q),
    .nn_next   (nn_rank),
    .knn_next  (knn_rank),
    .kcnt_next (kcnt_rank)
  );

  always_comb begin
    state_d   = state_q;
    ss_d      = i_ss_1;
    fc_d      = fc_q;
    pw_d      = pw_q;
    en_d      = en_q;
    k_d       = k_q;
    arrived_d = arrived_q;
    kcnt_d    = kcnt_q;
    pwm_d     = pwm_q;
    cnt_d     = cnt_q;
    nn_d      = nn_q;
    knn_d     = knn_q;
    if (commit) begin
      // Commit wins from any state, so a RUN abort drops its partial results here.
      state_d = ST_ARM;
      pwm_d   = '0;
      cnt_d   = '0;
      nn_d    = '0;
      knn_d   = '0;
    end else begin
      unique case (state_q)
        ST_ARM: begin
          pw_d      = i_pw;
          en_d      = i_switch;
          k_d       = i_knn_k;
          fc_d      = '0;
          arrived_d = '0;
          kcnt_d    = '0;
          nn_d      = '0;
          knn_d     = '0;
          for (int c = 0; c < NCH; c++) begin
            cnt_d[c*CW +: CW] = i_switch[c] ? FRAME_MAX : '0;
            pwm_d[c]          = i_switch[c] && (ch_slice(i_pw, c) != '0);
          end
          state_d = (i_switch != '0) ? ST_RUN : ST_DONE;
        end
        ST_RUN: begin
          arrived_d = arrived_q | arrive;
          nn_d      = nn_rank;
          knn_d     = knn_rank;
          kcnt_d    = kcnt_rank;
          for (int c = 0; c < NCH; c++) begin
            if (arrive[c]) cnt_d[c*CW +: CW] = fc_q;
          end
          if (frame_end) begin
            state_d = ST_DONE;
            pwm_d   = '0;
          end else begin
            // PWM is registered, so it is computed against the next frame count.
            fc_d = fc_inc;
            for (int c = 0; c < NCH; c++) begin
              pwm_d[c] = en_q[c] && (fc_inc < ch_slice(pw_q, c));
            end
`ifdef WTA_INHIBIT_EN
            if (nn_rank != '0) pwm_d = pwm_d & nn_rank;
`endif
          end
        end
        default: pwm_d = '0;
      endcase
    end
    busy_d = (state_d == ST_ARM) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ss_q      <= 1'b0;
      fc_q      <= '0;
      pw_q      <= '0;
      en_q      <= '0;
      k_q       <= '0;
      arrived_q <= '0;
      kcnt_q    <= '0;
      pwm_q     <= '0;
      cnt_q     <= '0;
      nn_q      <= '0;
      knn_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_q      <= ss_d;
      fc_q      <= fc_d;
      pw_q      <= pw_d;
      en_q      <= en_d;
      k_q       <= k_d;
      arrived_q <= arrived_d;
      kcnt_q    <= kcnt_d;
      pwm_q     <= pwm_d;
      cnt_q     <= cnt_d;
      nn_q      <= nn_d;
      knn_q     <= knn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_pwm  = pwm_q;
  assign o_cnt  = cnt_q;
  assign o_nn   = nn_q;
  assign o_knn  = knn_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_wta_frame_ctrl.sv
// tb/tb_wta_frame_ctrl.sv - self-checking bench for wta_frame_ctrl against a frame-level reference model
module tb_wta_frame_ctrl;
  import wta_pkg::*;

  localparam int NONE = 100000;
  localparam int FMAX = FRAME_MAX;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_ss_1 = 1'b0;
  logic [NCH*CW-1:0] i_pw = '0;
  logic [NCH-1:0]    i_switch = '0;
  logic [KW-1:0]     i_knn_k = '0;
  logic [NCH-1:0]    i_pulse = '0;
  logic [NCH-1:0]    o_pwm;
  logic [NCH*CW-1:0] o_cnt;
  logic [NCH-1:0]    o_nn;
  logic [NCH-1:0]    o_knn;
  logic              o_busy;
  logic              o_done;

  int errors = 0;
  int checks = 0;

  // Per-channel first-high frame count of the response pulse (NONE = never).
  int arr_t[NCH];

  int             m_end, m_win, m_win_t;
  int             m_cnt[NCH];
  logic [NCH-1:0] m_nn, m_knn;

  always #5 clk = ~clk;

  wta_frame_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_ss_1   (i_ss_1),
    .i_pw     (i_pw),
    .i_switch (i_switch),
    .i_knn_k  (i_knn_k),
    .i_pulse  (i_pulse),
    .o_pwm    (o_pwm),
    .o_cnt    (o_cnt),
    .o_nn     (o_nn),
    .o_knn    (o_knn),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  task automatic build_model(input logic [NCH-1:0] en, input int k);
    int all_in;
    int mx;
    int best;
    int bt;
    all_in = 1;
    mx = 0;
    for (int c = 0; c < NCH; c++) begin
      if (en[c]) begin
        if (arr_t[c] > FMAX) all_in = 0;
        else if (arr_t[c] > mx) mx = arr_t[c];
      end
    end
    m_end = all_in ? mx : FMAX;
    for (int c = 0; c < NCH; c++)
      m_cnt[c] = !en[c] ? 0 : ((arr_t[c] <= m_end) ? arr_t[c] : FMAX);
    m_win = -1;
    m_win_t = NONE;
    for (int c = 0; c < NCH; c++) begin
      if (en[c] && arr_t[c] <= m_end && arr_t[c] < m_win_t) begin
        m_win = c;
        m_win_t = arr_t[c];
      end
    end
    m_nn = '0;
    if (m_win >= 0) m_nn[m_win] = 1'b1;
    m_knn = '0;
    for (int r = 0; r < k; r++) begin
      best = -1;
      bt = NONE;
      for (int c = 0; c < NCH; c++) begin
        if (en[c] && !m_knn[c] && arr_t[c] <= m_end && arr_t[c] < bt) begin
          best = c;
          bt = arr_t[c];
        end
      end
      if (best >= 0) m_knn[best] = 1'b1;
    end
  endtask

  function automatic logic [NCH-1:0] exp_pwm(input int n, input logic [NCH*CW-1:0] pw,
                                             input logic [NCH-1:0] en);
    logic [NCH-1:0] p;
    for (int c = 0; c < NCH; c++) p[c] = en[c] && (n < int'(pw[c*CW +: CW]));
`ifdef WTA_INHIBIT_EN
    if (m_win >= 0 && n > m_win_t) p = p & m_nn;
`endif
    return p;
  endfunction

  task automatic drive_frame(input logic [NCH*CW-1:0] pw, input logic [NCH-1:0] en,
                             input logic [KW-1:0] k, input bit do_commit, input int abort_at,
                             input string tag);
    int                last, pwm_bad, busy_bad, bad_n;
    logic [NCH-1:0]    exp_p, bad_act, bad_exp;
    logic [NCH*CW-1:0] exp_c, exp_final;
    pwm_bad = 0;
    busy_bad = 0;
    bad_n = -1;
    bad_act = '0;
    bad_exp = '0;
    build_model(en, int'(k));
    for (int c = 0; c < NCH; c++) begin
      exp_c[c*CW +: CW] = en[c] ? FRAME_MAX : '0;
      exp_final[c*CW +: CW] = CW'(m_cnt[c]);
    end
    i_pw = pw;
    i_switch = en;
    i_knn_k = k;
    i_pulse = '0;
    if (do_commit) begin
      i_ss_1 = 1'b1;
      @(negedge clk);
      i_ss_1 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL arm_%s: busy=%b done=%b, want busy=1 done=0", tag, o_busy, o_done);
    end
    @(negedge clk);
    last = (abort_at >= 0) ? abort_at : ((en == '0) ? -1 : m_end);
    for (int n = 0; n <= last; n++) begin
      if (n == 0) begin
        checks++;
        if (o_cnt !== exp_c || o_nn !== '0 || o_knn !== '0) begin
          errors++;
          $display("FAIL clear_%s: cnt=%h nn=%h knn=%h, want cnt=%h nn=0 knn=0",
                   tag, o_cnt, o_nn, o_knn, exp_c);
        end
      end
      exp_p = exp_pwm(n, pw, en);
      if (o_pwm !== exp_p) begin
        pwm_bad++;
        if (bad_n < 0) begin
          bad_n = n;
          bad_act = o_pwm;
          bad_exp = exp_p;
        end
      end
      if (o_busy !== 1'b1 || o_done !== 1'b0) busy_bad++;
      // Config lines carry unrelated SPI traffic during the frame.
      i_pw = {$urandom, $urandom, $urandom};
      i_switch = NCH'($urandom);
      i_knn_k = KW'($urandom);
      for (int c = 0; c < NCH; c++) i_pulse[c] = (arr_t[c] <= n);
      if (abort_at >= 0 && n == abort_at - 1) i_ss_1 = 1'b1;
      if (abort_at >= 0 && n == abort_at) i_ss_1 = 1'b0;
      @(negedge clk);
    end
    if (last >= 0) begin
      checks++;
      if (pwm_bad != 0) begin
        errors++;
        $display("FAIL pwm_%s: %0d bad cycles, first at fc=%0d got %b want %b",
                 tag, pwm_bad, bad_n, bad_act, bad_exp);
      end
      checks++;
      if (busy_bad != 0) begin
        errors++;
        $display("FAIL run_busy_%s: %0d cycles without busy=1 done=0, want 0", tag, busy_bad);
      end
    end
    if (abort_at < 0) begin
      checks++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_pwm !== '0) begin
        errors++;
        $display("FAIL done_%s: done=%b busy=%b pwm=%b, want done=1 busy=0 pwm=0",
                 tag, o_done, o_busy, o_pwm);
      end
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (o_cnt[c*CW +: CW] !== CW'(m_cnt[c])) begin
          errors++;
          $display("FAIL cnt%0d_%s: got %0d want %0d", c, tag, o_cnt[c*CW +: CW], m_cnt[c]);
        end
      end
      checks++;
      if (o_nn !== m_nn) begin
        errors++;
        $display("FAIL nn_%s: got %h want %h", tag, o_nn, m_nn);
      end
      checks++;
      if (o_knn !== m_knn) begin
        errors++;
        $display("FAIL knn_%s: got %h want %h", tag, o_knn, m_knn);
      end
      i_pulse = '1;
      i_pw = {$urandom, $urandom, $urandom};
      i_switch = NCH'($urandom);
      @(negedge clk);
      checks++;
      if (o_done !== 1'b1 || o_nn !== m_nn || o_knn !== m_knn || o_cnt !== exp_final) begin
        errors++;
        $display("FAIL hold_%s: done=%b nn=%h knn=%h cnt=%h, want done=1 nn=%h knn=%h cnt=%h",
                 tag, o_done, o_nn, o_knn, o_cnt, m_nn, m_knn, exp_final);
      end
      i_pulse = '0;
    end
  endtask

  task automatic test_reset;
    logic [NCH*CW-1:0] pw;
    rst_n = 1'b0;
    i_ss_1 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_pwm !== '0 || o_cnt !== '0 || o_nn !== '0 || o_knn !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: pwm=%h cnt=%h nn=%h knn=%h busy=%b done=%b, want all 0",
               o_pwm, o_cnt, o_nn, o_knn, o_busy, o_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    i_ss_1 = 1'b0;
    @(negedge clk);
    pw = '0;
    pw[0*CW +: CW] = CW'(3);
    pw[1*CW +: CW] = CW'(7);
    for (int c = 0; c < NCH; c++) arr_t[c] = NONE;
    arr_t[0] = 2;
    arr_t[1] = 4;
    drive_frame(pw, 8'h03, 3'd1, 1'b0, -1, "post_reset");
  endtask

  task automatic test_timeout;
    logic [NCH*CW-1:0] pw;
    pw = {$urandom, $urandom, $urandom};
    pw[0*CW +: CW] = CW'(5);
    pw[3*CW +: CW] = CW'(0);
    for (int c = 0; c < NCH; c++) arr_t[c] = NONE;
    drive_frame(pw, 8'h09, 3'd2, 1'b1, -1, "timeout");
  endtask

  task automatic test_ranking;
    logic [NCH*CW-1:0] pw;
    for (int c = 0; c < NCH; c++) begin
      pw[c*CW +: CW] = CW'($urandom_range(0, 40));
      arr_t[c] = 30;
    end
    arr_t[5] = 10;
    arr_t[1] = 20;
    arr_t[2] = 20;
    arr_t[6] = 20;
    drive_frame(pw, 8'hFF, 3'd3, 1'b1, -1, "rank");
  endtask

  task automatic test_en_zero;
    logic [NCH*CW-1:0] pw;
    for (int c = 0; c < NCH; c++) begin
      pw[c*CW +: CW] = CW'($urandom_range(1, 50));
      arr_t[c] = $urandom_range(0, 5);
    end
    drive_frame(pw, 8'h00, 3'd5, 1'b1, -1, "en_zero");
  endtask

  task automatic test_abort;
    logic [NCH*CW-1:0] pw;
    for (int c = 0; c < NCH; c++) begin
      pw[c*CW +: CW] = CW'(150);
      arr_t[c] = NONE;
    end
    arr_t[0] = 5;
    arr_t[3] = 50;
    drive_frame(pw, 8'hFF, 3'd2, 1'b1, 100, "abort_a");
    for (int c = 0; c < NCH; c++) begin
      pw[c*CW +: CW] = CW'($urandom_range(0, 60));
      arr_t[c] = NONE;
    end
    arr_t[0] = 5;
    arr_t[2] = 7;
    arr_t[3] = 7;
    arr_t[4] = 12;
    arr_t[5] = 40;
    drive_frame(pw, 8'h3C, 3'd2, 1'b0, -1, "abort_b");
  endtask

  task automatic test_inhibit_pattern;
    logic [NCH*CW-1:0] pw;
    for (int c = 0; c < NCH; c++) begin
      pw[c*CW +: CW] = CW'(50);
      arr_t[c] = 60;
    end
    arr_t[2] = 3;
    drive_frame(pw, 8'hFF, 3'd1, 1'b1, -1, "inhibit");
  endtask

  task automatic test_random;
    logic [NCH*CW-1:0] pw;
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < NCH; c++) begin
        pw[c*CW +: CW] = CW'($urandom_range(0, 80));
        arr_t[c] = $urandom_range(0, 60);
      end
      if (f == 4) arr_t[$urandom_range(0, NCH - 1)] = NONE;
      drive_frame(pw, NCH'($urandom), KW'($urandom), 1'b1, -1, $sformatf("rnd%0d", f));
    end
  endtask

  task automatic test_async_reset;
    logic [NCH*CW-1:0] pw;
    logic [NCH-1:0]    exp_p;
    for (int c = 0; c < NCH; c++) begin
      pw[c*CW +: CW] = CW'(200);
      arr_t[c] = NONE;
    end
    i_pw = pw;
    i_switch = '1;
    i_knn_k = 3'd2;
    i_pulse = '0;
    i_ss_1 = 1'b1;
    @(negedge clk);
    i_ss_1 = 1'b0;
    @(negedge clk);
    repeat (10) @(negedge clk);
    i_pulse = 8'h10;
    @(negedge clk);
`ifdef WTA_INHIBIT_EN
    exp_p = 8'h10;
`else
    exp_p = 8'hFF;
`endif
    checks++;
    if (o_nn !== 8'h10 || o_pwm !== exp_p || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_async: nn=%h pwm=%h busy=%b, want nn=10 pwm=%h busy=1", o_nn, o_pwm, o_busy, exp_p);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_pwm !== '0 || o_cnt !== '0 || o_nn !== '0 || o_knn !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pwm=%h cnt=%h nn=%h knn=%h busy=%b done=%b, want all 0",
               o_pwm, o_cnt, o_nn, o_knn, o_busy, o_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_pulse = '0;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      pw[c*CW +: CW] = CW'($urandom_range(0, 30));
      arr_t[c] = $urandom_range(0, 25);
    end
    drive_frame(pw, 8'hA5, 3'd7, 1'b1, -1, "after_async");
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_ranking();
    test_en_zero();
    test_abort();
    test_inhibit_pattern();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
